alu_req_sequencer: RTL

- Shares one WIDTH-bit ALU datapath between two requesters using round-robin arbitration.
- Supports add/sub, multiply, divide and logic/compare operations.
- Multiply and divide are iterative (WIDTH cycles, one bit per cycle); all other ops complete in one cycle.
- Sits between the requester pipelines and the result writeback, with valid/ready handshakes on both sides.

---
 rtl/alu_req_sequencer_if.sv | 30 +++
 rtl/alu_req_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_req_sequencer_if.sv
// Requester/writeback bundle for alu_req_sequencer: two request ports sharing one
// response port. master = requesters plus sink, slave = sequencer.
interface alu_req_sequencer_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [3:0]       req_op0;
  logic [3:0]       req_op1;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_b1;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result1;
  logic [WIDTH-1:0] rsp_result2;
  logic             rsp_arith;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result1, rsp_result2, rsp_arith
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result1, rsp_result2, rsp_arith
  );
endinterface

// File: rtl/alu_req_sequencer.sv
// Round-robin sharing of one ALU between two requesters; mul/div iterate one bit per cycle.
// state | meaning: IDLE = arbitrate/accept, EXEC = mul/div iterating, RESP = result offered
module alu_req_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_req_sequencer_if.slave   bus,
  output logic                 busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_MUL = 4'b0001;
  localparam logic [3:0] OP_DIV = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;

  logic [1:0]       state_q, state_d;
  logic             rr_q, rr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] res1_q, res1_d;
  logic [WIDTH-1:0] res2_q, res2_d;
  logic             arith_q, arith_d;

  logic             gnt_id;
  logic [1:0]       req_ready;
  logic             accept;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    gnt_id = rr_q;
    if (!bus.req_valid[rr_q]) gnt_id = ~rr_q;
    req_ready = 2'b00;
    if (state_q == S_IDLE && !rst && (|bus.req_valid))
      req_ready = gnt_id ? 2'b10 : 2'b01;
    accept = |(bus.req_valid & req_ready);
    sel_op = gnt_id ? bus.req_op1 : bus.req_op0;
    sel_a  = gnt_id ? bus.req_a1  : bus.req_a0;
    sel_b  = gnt_id ? bus.req_b1  : bus.req_b0;
  end

  // One iteration step. Mul keeps {acc,lo} as the shifting product with the
  // multiplier in lo; div keeps remainder in acc and dividend/quotient in lo.
  // Either way result1 = lo and result2 = acc once WIDTH steps are done.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_sh   = {acc_q, lo_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, a_q});
    div_diff = div_sh[WIDTH-1:0] - a_q;
    if (div_q) begin
      step_acc = div_ge ? div_diff : div_sh[WIDTH-1:0];
      step_lo  = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_acc = mul_sum[WIDTH:1];
      step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    id_d     = id_q;
    a_d      = a_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    rsp_id_d = rsp_id_q;
    res1_d   = res1_q;
    res2_d   = res2_q;
    arith_d  = arith_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          id_d = gnt_id;
          rr_d = ~gnt_id;
          case (sel_op)
            OP_MUL, OP_DIV: begin
              div_d   = (sel_op == OP_DIV);
              a_d     = (sel_op == OP_DIV) ? sel_b : sel_a;
              lo_d    = (sel_op == OP_DIV) ? sel_a : sel_b;
              acc_d   = '0;
              cnt_d   = CNT_INIT;
              state_d = S_EXEC;
            end
            default: begin
              rsp_id_d = gnt_id;
              state_d  = S_RESP;
              res1_d   = '0;
              res2_d   = '0;
              arith_d  = 1'b0;
              if (sel_op == OP_ADD) begin
                res1_d  = sel_a + sel_b;
                res2_d  = sel_a - sel_b;
                arith_d = 1'b1;
              end else if (sel_op == OP_XOR) begin
                res1_d = sel_a ^ sel_b;
                res2_d = WIDTH'(sel_a == sel_b);
              end
            end
          endcase
        end
      end
      S_EXEC: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          res1_d   = step_lo;
          res2_d   = step_acc;
          arith_d  = 1'b1;
          rsp_id_d = id_q;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_q     <= 1'b0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      id_q     <= 1'b0;
      a_q      <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      rsp_id_q <= 1'b0;
      res1_q   <= '0;
      res2_q   <= '0;
      arith_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      id_q     <= id_d;
      a_q      <= a_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      rsp_id_q <= rsp_id_d;
      res1_q   <= res1_d;
      res2_q   <= res2_d;
      arith_q  <= arith_d;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_result1 = res1_q;
  assign bus.rsp_result2 = res2_q;
  assign bus.rsp_arith   = arith_q;
  assign busy            = (state_q != S_IDLE);
endmodule
